mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS datapath: sequences each instruction through fetch, decode, execute, memory and writeback, decodes IR into the 4-bit ALUOp code the ALU consumes, and drives all datapath write strobes and mux selects. Sits between the instruction register and the datapath; it is the initiator of every ALU operation and the sole consumer of the ALU `zero` flag.

---
 rtl/mc_pkg.sv | 92 +++++++++
 rtl/mc_ctrl_if.sv | 32 +++
 rtl/mc_decode.sv | 75 +++++++
 rtl/mc_ctrl.sv | 157 +++++++++++++++
 tb/tb_mc_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS controller, datapath and ALU
//
// Contents: FSM state encoding, instruction classes, ALUOp codes,
// opcode/funct values and the NPCOp/RegDst/WDSel/ExtOp select encodings.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CLS_R_ALU,
    CLS_I_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_UNKNOWN
  } inst_class_t;

  localparam logic [3:0] ALU_NOP  = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_SLL  = 4'h3;
  localparam logic [3:0] ALU_SLLV = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_SRLV = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SRAV = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;
  localparam logic [3:0] ALU_OR   = 4'hA;
  localparam logic [3:0] ALU_XOR  = 4'hB;
  localparam logic [3:0] ALU_NOR  = 4'hC;
  localparam logic [3:0] ALU_SLT  = 4'hD;
  localparam logic [3:0] ALU_SLTU = 4'hE;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - signal bundle between the controller and the datapath
//
// master: controller side (consumes IR/zero, drives strobes, selects, debug).
// slave : datapath side (supplies IR/zero, consumes everything else).
interface mc_ctrl_if;
  logic [31:0] IR;
  logic        zero;
  logic [3:0]  ALUOp;
  logic        PCWr;
  logic [1:0]  NPCOp;
  logic        IRWr;
  logic        RegWr;
  logic [1:0]  RegDst;
  logic [1:0]  WDSel;
  logic        ALUSrcB;
  logic [1:0]  ExtOp;
  logic        MemWr;
  logic [2:0]  state;
  logic [31:0] retired;

  modport master (
    input  IR, zero,
    output ALUOp, PCWr, NPCOp, IRWr, RegWr, RegDst, WDSel, ALUSrcB, ExtOp, MemWr,
           state, retired
  );

  modport slave (
    output IR, zero,
    input  ALUOp, PCWr, NPCOp, IRWr, RegWr, RegDst, WDSel, ALUSrcB, ExtOp, MemWr,
           state, retired
  );
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational IR classifier for the multi-cycle controller
//
// Ports: ir (in, 32) instruction; cls (out) instruction class;
// alu_op (out, 4) ALU operation; ext_op (out, 2) immediate extension;
// alu_src_b (out, 1) selects extended immediate as ALU operand B.
// MC_CTRL_SHIFT_EN: when defined the six shift functs decode as R-type ALU
// ops; otherwise they fall into the unknown class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0]  ir,
  output inst_class_t  cls,
  output logic [3:0]   alu_op,
  output logic [1:0]   ext_op,
  output logic         alu_src_b
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  // Register and immediate fields are routed by the datapath, not decoded here.
  assign unused_fields = ^ir[25:6];

  always_comb begin
    cls       = CLS_UNKNOWN;
    alu_op    = ALU_NOP;
    ext_op    = EXT_ZERO;
    alu_src_b = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_R_ALU;
        case (funct)
          FN_JR:   begin cls = CLS_JR; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
`ifdef MC_CTRL_SHIFT_EN
          FN_SLL:  alu_op = ALU_SLL;
          FN_SLLV: alu_op = ALU_SLLV;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRLV: alu_op = ALU_SRLV;
          FN_SRA:  alu_op = ALU_SRA;
          FN_SRAV: alu_op = ALU_SRAV;
`endif
          default: cls = CLS_UNKNOWN;
        endcase
      end
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      // Branch offset is sign-extended for the target adder; the ALU only compares rs/rt.
      OP_BEQ:   begin cls = CLS_BEQ; alu_op = ALU_SUB; ext_op = EXT_SIGN; end
      OP_BNE:   begin cls = CLS_BNE; alu_op = ALU_SUB; ext_op = EXT_SIGN; end
      OP_ADDIU: begin cls = CLS_I_ALU; alu_op = ALU_ADD;  ext_op = EXT_SIGN; alu_src_b = 1'b1; end
      OP_SLTI:  begin cls = CLS_I_ALU; alu_op = ALU_SLT;  ext_op = EXT_SIGN; alu_src_b = 1'b1; end
      OP_SLTIU: begin cls = CLS_I_ALU; alu_op = ALU_SLTU; ext_op = EXT_SIGN; alu_src_b = 1'b1; end
      OP_ANDI:  begin cls = CLS_I_ALU; alu_op = ALU_AND;  ext_op = EXT_ZERO; alu_src_b = 1'b1; end
      OP_ORI:   begin cls = CLS_I_ALU; alu_op = ALU_OR;   ext_op = EXT_ZERO; alu_src_b = 1'b1; end
      OP_XORI:  begin cls = CLS_I_ALU; alu_op = ALU_XOR;  ext_op = EXT_ZERO; alu_src_b = 1'b1; end
      // lui: rs is $0 by convention, so ADD of the upper-extended immediate yields imm<<16.
      OP_LUI:   begin cls = CLS_I_ALU; alu_op = ALU_ADD;  ext_op = EXT_UPPER; alu_src_b = 1'b1; end
      OP_LW:    begin cls = CLS_LOAD;  alu_op = ALU_ADD;  ext_op = EXT_SIGN; alu_src_b = 1'b1; end
      OP_SW:    begin cls = CLS_STORE; alu_op = ALU_ADD;  ext_op = EXT_SIGN; alu_src_b = 1'b1; end
      default:  cls = CLS_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM (fetch/decode/exe/mem/wb)
//
// Ports: clk (in) rising-edge clock; reset (in) synchronous active-high;
// bus (mc_ctrl_if.master): IR/zero in; ALUOp, PCWr, NPCOp, IRWr, RegWr, RegDst,
// WDSel, ALUSrcB, ExtOp, MemWr, state, retired out.
// MC_CTRL_SHIFT_EN (see mc_decode) enables decoding of the shift instructions.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] retired_q;

  inst_class_t cls;
  logic [3:0]  dec_alu_op;
  logic [1:0]  dec_ext_op;
  logic        dec_alu_src_b;
  logic        br_taken;

  logic [3:0]  alu_op;
  logic        pc_wr;
  logic [1:0]  npc_op;
  logic        ir_wr;
  logic        reg_wr;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        alu_src_b;
  logic [1:0]  ext_op;
  logic        mem_wr;

  mc_decode u_decode (
    .ir        (bus.IR),
    .cls       (cls),
    .alu_op    (dec_alu_op),
    .ext_op    (dec_ext_op),
    .alu_src_b (dec_alu_src_b)
  );

  assign br_taken = ((cls == CLS_BEQ) &&  bus.zero) ||
                    ((cls == CLS_BNE) && !bus.zero);

  // State register and retirement counter. An instruction retires on the
  // edge that returns the FSM to FETCH; a reset abort does not count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != ST_FETCH && state_d == ST_FETCH) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (cls)
          CLS_J, CLS_JAL, CLS_JR, CLS_UNKNOWN: state_d = ST_FETCH;
          default:                             state_d = ST_EXE;
        endcase
      end
      ST_EXE: begin
        case (cls)
          CLS_BEQ, CLS_BNE:    state_d = ST_FETCH;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM:  state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are suppressed while reset is high so an aborted instruction
  // cannot write anything in the reset cycle.
  always_comb begin
    alu_op    = ALU_NOP;
    pc_wr     = 1'b0;
    npc_op    = NPC_PC4;
    ir_wr     = 1'b0;
    reg_wr    = 1'b0;
    reg_dst   = RD_RT;
    wd_sel    = WD_ALU;
    alu_src_b = 1'b0;
    ext_op    = EXT_ZERO;
    mem_wr    = 1'b0;
    if (!reset) begin
      // ALU controls stay at their EXE values through MEM and WB.
      if (state_q == ST_EXE || state_q == ST_MEM || state_q == ST_WB) begin
        alu_op    = dec_alu_op;
        alu_src_b = dec_alu_src_b;
        ext_op    = dec_ext_op;
      end
      case (state_q)
        ST_FETCH: begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
        ST_DECODE: begin
          case (cls)
            CLS_J: begin
              pc_wr  = 1'b1;
              npc_op = NPC_JUMP;
            end
            CLS_JAL: begin
              pc_wr   = 1'b1;
              npc_op  = NPC_JUMP;
              reg_wr  = 1'b1;
              reg_dst = RD_RA;
              wd_sel  = WD_PC4;
            end
            CLS_JR: begin
              pc_wr  = 1'b1;
              npc_op = NPC_JR;
            end
            default: ;
          endcase
        end
        ST_EXE: begin
          pc_wr  = br_taken;
          npc_op = br_taken ? NPC_BRANCH : NPC_PC4;
        end
        ST_MEM: mem_wr = (cls == CLS_STORE);
        ST_WB: begin
          reg_wr  = 1'b1;
          reg_dst = (cls == CLS_R_ALU) ? RD_RD : RD_RT;
          wd_sel  = (cls == CLS_LOAD) ? WD_MEM : WD_ALU;
        end
        default: ;
      endcase
    end
  end

  assign bus.ALUOp   = alu_op;
  assign bus.PCWr    = pc_wr;
  assign bus.NPCOp   = npc_op;
  assign bus.IRWr    = ir_wr;
  assign bus.RegWr   = reg_wr;
  assign bus.RegDst  = reg_dst;
  assign bus.WDSel   = wd_sel;
  assign bus.ALUSrcB = alu_src_b;
  assign bus.ExtOp   = ext_op;
  assign bus.MemWr   = mem_wr;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl with a per-instruction reference model
module tb_mc_ctrl;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                 K_J = 6, K_JAL = 7, K_JR = 8, K_UNK = 9;

  // ctrl vector: {ALUOp[16:13], PCWr[12], NPCOp[11:10], IRWr[9], RegWr[8],
  //               RegDst[7:6], WDSel[5:4], ALUSrcB[3], ExtOp[2:1], MemWr[0]}
  localparam logic [16:0] M_SRCB = 17'h00008;
  localparam logic [16:0] M_EXT  = 17'h00006;

  typedef struct {
    logic [16:0] ctrl;
    logic [16:0] care;
    logic [2:0]  st;
    logic [31:0] ret;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_no = 0;
  logic [31:0] exp_ret = '0;

  logic [5:0] rfn [0:15] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                             6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h3F};
  logic [5:0] iop [0:13] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                             6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3E};

  task automatic check(input string nm, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int classify(input logic [31:0] ir);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    case (op)
      6'h00: begin
        case (fn)
          6'h08: return K_JR;
          6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return K_R;
`ifdef MC_CTRL_SHIFT_EN
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: return K_R;
`endif
          default: return K_UNK;
        endcase
      end
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return K_I;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      default: return K_UNK;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] ir);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h21: return 4'h1;  6'h23: return 4'h2;
        6'h00: return 4'h3;  6'h04: return 4'h4;
        6'h02: return 4'h5;  6'h06: return 4'h6;
        6'h03: return 4'h7;  6'h07: return 4'h8;
        6'h24: return 4'h9;  6'h25: return 4'hA;
        6'h26: return 4'hB;  6'h27: return 4'hC;
        6'h2A: return 4'hD;  6'h2B: return 4'hE;
        default: return 4'h0;
      endcase
    end
    case (op)
      6'h04, 6'h05: return 4'h2;
      6'h09, 6'h0F, 6'h23, 6'h2B: return 4'h1;
      6'h0A: return 4'hD;
      6'h0B: return 4'hE;
      6'h0C: return 4'h9;
      6'h0D: return 4'hA;
      6'h0E: return 4'hB;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [1:0] ext_of(input logic [31:0] ir);
    case (ir[31:26])
      6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: return 2'd1;
      6'h0F: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // One instruction: the cycle count per class fixes the phase sequence;
  // each cycle's expected outputs are queued for the monitor. zmode 0/1 forces
  // zero, 2 randomizes it; rst_last asserts reset in the final cycle.
  task automatic run_instr(input logic [31:0] ir, input int zmode, input bit rst_last);
    int k;
    int n;
    k = classify(ir);
    if (k == K_J || k == K_JAL || k == K_JR || k == K_UNK) n = 2;
    else if (k == K_BEQ || k == K_BNE) n = 3;
    else if (k == K_LW) n = 5;
    else n = 4;
    for (int p = 0; p < n; p++) begin
      int          ph;
      logic        z;
      logic        taken;
      logic [3:0]  aluop;
      logic        pcwr, irwr, regwr, srcb, memwr;
      logic [1:0]  npc, regdst, wdsel, ext;
      logic [16:0] care;
      exp_t        e;
      ph = ((k == K_R || k == K_I) && p == 3) ? 4 : p;
      @(posedge clk);
      #1;
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      bus.IR = ir;
      bus.zero = z;
      reset = rst_last && (p == n - 1);
      aluop = 4'h0; pcwr = 1'b0; npc = 2'd0; irwr = 1'b0; regwr = 1'b0;
      regdst = 2'd0; wdsel = 2'd0; srcb = 1'b0; ext = 2'd0; memwr = 1'b0;
      care = '1;
      if (ph == 0) begin
        irwr = 1'b1;
        pcwr = 1'b1;
      end else if (ph == 1) begin
        if (k == K_J || k == K_JAL) begin pcwr = 1'b1; npc = 2'd2; end
        if (k == K_JAL) begin regwr = 1'b1; regdst = 2'd2; wdsel = 2'd2; end
        if (k == K_JR) begin pcwr = 1'b1; npc = 2'd3; end
      end else begin
        aluop = alu_of(ir);
        srcb = (k == K_I || k == K_LW || k == K_SW);
        ext = ext_of(ir);
        if (ph == 2 && (k == K_BEQ || k == K_BNE)) begin
          taken = (k == K_BEQ) ? z : !z;
          pcwr = taken;
          npc = taken ? 2'd1 : 2'd0;
          care = care & ~M_EXT;
        end
        if (ph >= 3) care = care & ~M_SRCB & ~M_EXT;
        if (ph == 3) memwr = (k == K_SW);
        if (ph == 4) begin
          regwr = 1'b1;
          regdst = (k == K_R) ? 2'd1 : 2'd0;
          wdsel = (k == K_LW) ? 2'd1 : 2'd0;
        end
      end
      e.ctrl = reset ? 17'h0 : {aluop, pcwr, npc, irwr, regwr, regdst, wdsel, srcb, ext, memwr};
      e.care = reset ? 17'h1FFFF : care;
      e.st = 3'(ph);
      e.ret = exp_ret;
      e.cyc = cyc_no;
      sb.push_back(e);
      cyc_no++;
    end
    if (rst_last) exp_ret = '0;
    else exp_ret = exp_ret + 32'd1;
  endtask

  task automatic rand_ir(output logic [31:0] ir);
    int sel;
    ir = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 4) begin
      ir[31:26] = 6'h00;
      ir[5:0] = rfn[$urandom_range(0, 15)];
    end else if (sel < 9) begin
      ir[31:26] = iop[$urandom_range(0, 13)];
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] act;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      act = {bus.ALUOp, bus.PCWr, bus.NPCOp, bus.IRWr, bus.RegWr, bus.RegDst,
             bus.WDSel, bus.ALUSrcB, bus.ExtOp, bus.MemWr};
      check("ctrl", e.cyc, 32'(act & e.care), 32'(e.ctrl & e.care));
      check("state", e.cyc, 32'(bus.state), 32'(e.st));
      check("retired", e.cyc, bus.retired, e.ret);
    end
  end

  initial begin
    logic [31:0] ir;
    exp_t        e;
    bus.IR = 32'h0;
    bus.zero = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    // Reset still high: everything quiet, state FETCH, nothing retired.
    #1;
    e.ctrl = '0; e.care = '1; e.st = 3'd0; e.ret = '0; e.cyc = cyc_no;
    sb.push_back(e);
    cyc_no++;

    run_instr(32'h00221821, 2, 1'b0);  // addu $3,$1,$2
    run_instr(32'h8CA40008, 2, 1'b0);  // lw $4,8($5)
    run_instr(32'h10220003, 1, 1'b0);  // beq taken
    run_instr(32'h10220003, 0, 1'b0);  // beq not taken
    run_instr(32'h14220003, 0, 1'b0);  // bne taken
    run_instr(32'h14220003, 1, 1'b0);  // bne not taken
    run_instr(32'h0C000010, 2, 1'b0);  // jal
    run_instr(32'h08000010, 2, 1'b0);  // j
    run_instr(32'h03E00008, 2, 1'b0);  // jr $31
    run_instr(32'h00011100, 2, 1'b0);  // sll $2,$1,4
    run_instr(32'h00000000, 2, 1'b0);  // sll $0,$0,0
    run_instr(32'h3C011234, 2, 1'b0);  // lui
    run_instr(32'h34210005, 2, 1'b0);  // ori
    run_instr(32'h2821FFFF, 2, 1'b0);  // slti
    run_instr(32'hACA40008, 2, 1'b0);  // sw
    run_instr(32'hFC000000, 2, 1'b0);  // unknown opcode
    run_instr(32'hACA40008, 2, 1'b1);  // sw aborted by reset in MEM
    run_instr(32'h00221821, 2, 1'b0);  // restart from retired=0
    run_instr(32'h8CA40008, 2, 1'b1);  // lw aborted by reset in WB

    for (int i = 0; i < 300; i++) begin
      rand_ir(ir);
      run_instr(ir, 2, ($urandom_range(0, 39) == 0));
    end

    repeat (3) @(posedge clk);
    check("drain", cyc_no, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
